instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue sequencer: walks instruction memory from address 0, follows
// opcode-110 jumps, hands executable ops to the datapath and stops on opcode 111.
module instr_sequencer #(
    parameter int unsigned INSTR_BIT = 8,
    parameter int unsigned INDEX_BIT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 imem_en,
    output logic [INSTR_BIT-1:0] imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    input  logic                 exec_ready,
    output logic [INSTR_BIT-1:0] pc,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          retired
);

    localparam int unsigned OPC_LSB = 29;
    localparam int unsigned JMP_LSB = OPC_LSB - INSTR_BIT;
    localparam logic [2:0]  OP_JUMP = 3'b110;
    localparam logic [2:0]  OP_HALT = 3'b111;
    localparam logic [15:0] RET_MAX = 16'hFFFF;

    // Jump target and three register-index fields must fit below the opcode.
    if (INSTR_BIT < 1 || INSTR_BIT > OPC_LSB || INDEX_BIT < 1 || 3 * INDEX_BIT > OPC_LSB) begin : g_param_check
        $error("instr_sequencer: unsupported INSTR_BIT/INDEX_BIT combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [INSTR_BIT-1:0]   pc_q, pc_d;
    logic [31:0]            instr_q, instr_d;
    logic [15:0]            retired_q, retired_d;
    logic                   imem_en_q, imem_en_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2:0]             opcode_c;

    assign opcode_c = imem_rdata[31:OPC_LSB];

    // Next state; status outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                instr_d = imem_rdata;
                if (opcode_c == OP_JUMP) begin
                    pc_d    = imem_rdata[OPC_LSB-1:JMP_LSB];
                    state_d = S_FETCH;
                end else if (opcode_c == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (exec_ready) begin
                    retired_d = (retired_q == RET_MAX) ? retired_q : retired_q + 16'd1;
                    pc_d      = pc_q + INSTR_BIT'(1);
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_en_d     = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_ISSUE);
        busy_d        = (state_d != S_IDLE) && (state_d != S_HALT);
        done_d        = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            retired_q     <= '0;
            imem_en_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            imem_en_q     <= imem_en_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign imem_en     = imem_en_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a one-cycle-latency instruction memory model.
module tb_instr_sequencer;

    localparam int unsigned IB = 8;
    localparam int unsigned XB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          imem_en;
    logic [IB-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          exec_ready;
    logic [IB-1:0] pc;
    logic          busy;
    logic          done;
    logic [15:0]   retired;

    instr_sequencer #(.INSTR_BIT(IB), .INDEX_BIT(XB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_ready  (exec_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int f_addr[$];
    int f_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log the current cycle's outputs, then advance to 1 time unit past the edge.
    task automatic tick();
        if (imem_en === 1'b1) begin
            f_addr.push_back(int'(imem_addr));
            f_cyc.push_back(cyc);
        end
        if (instr_valid === 1'b1) valid_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        f_addr.delete();
        f_cyc.delete();
        valid_cnt = 0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        exec_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", done, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hE000_0000;

        // Reset values and idling without start
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_instr", instr, 0);
        check("rst_retired", retired, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_imem_en", imem_en, 0);
        tick(); tick(); tick();
        check("idle_busy", busy, 0);
        check("idle_imem_en", imem_en, 0);
        check("idle_no_fetch", f_addr.size(), 0);

        // One executable op then halt
        mem[0] = 32'h0000_0000;
        mem[1] = 32'hE000_0000;
        exec_ready = 1'b1;
        pulse_start();
        check("t1_fetch_en", imem_en, 1);
        check("t1_fetch_addr", imem_addr, 0);
        check("t1_busy", busy, 1);
        run_to_done(20);
        check("t1_valid_cycles", valid_cnt, 1);
        check("t1_retired", retired, 1);
        check("t1_pc", pc, 1);
        check("t1_busy_halt", busy, 0);
        check("t1_instr", instr, 32'hE000_0000);
        check("t1_fetches", f_addr.size(), 2);
        if (f_cyc.size() >= 2) check("t1_exec_latency", f_cyc[1] - f_cyc[0], 3);
        tick(); tick();
        check("t1_halt_hold_done", done, 1);
        check("t1_halt_hold_pc", pc, 1);

        // Jump to 5 then halt
        do_reset();
        mem[0] = 32'hC0A0_0000;
        mem[5] = 32'hE000_0000;
        exec_ready = 1'b1;
        pulse_start();
        run_to_done(20);
        check("t2_fetches", f_addr.size(), 2);
        if (f_addr.size() >= 2) begin
            check("t2_addr0", f_addr[0], 0);
            check("t2_addr1", f_addr[1], 5);
            check("t2_jump_latency", f_cyc[1] - f_cyc[0], 2);
        end
        check("t2_retired", retired, 0);
        check("t2_pc", pc, 5);
        check("t2_valid_cycles", valid_cnt, 0);

        // Back-pressure: exec_ready low for the first 4 ISSUE cycles
        do_reset();
        mem[0] = 32'hA000_0000;
        mem[1] = 32'hE000_0000;
        exec_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_valid_%0d", k), instr_valid, 1);
            check($sformatf("t3_instr_%0d", k), instr, 32'hA000_0000);
            check($sformatf("t3_pc_%0d", k), pc, 0);
            if (k == 4) exec_ready = 1'b1;
            tick();
        end
        check("t3_valid_after", instr_valid, 0);
        check("t3_pc_after", pc, 1);
        check("t3_retired_after", retired, 1);
        check("t3_refetch", imem_en, 1);
        run_to_done(20);
        check("t3_valid_cycles", valid_cnt, 5);

        // Asynchronous reset in the middle of ISSUE
        do_reset();
        mem[0] = 32'hC020_0000;
        mem[1] = 32'hA000_0000;
        mem[2] = 32'hE000_0000;
        exec_ready = 1'b0;
        pulse_start();
        tick(); tick(); tick(); tick();
        check("t4_in_issue", instr_valid, 1);
        check("t4_pc_issue", pc, 1);
        rst = 1'b1;
        #1;
        check("t4_rst_valid", instr_valid, 0);
        check("t4_rst_pc", pc, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_imem_en", imem_en, 0);
        check("t4_rst_instr", instr, 0);
        rst = 1'b0;
        clear_logs();
        tick(); tick(); tick();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_no_fetch", f_addr.size(), 0);
        exec_ready = 1'b1;
        pulse_start();
        check("t4_restart_addr", imem_addr, 0);
        check("t4_restart_en", imem_en, 1);
        run_to_done(30);
        check("t4_pc", pc, 2);
        check("t4_retired", retired, 1);

        // Jump to 255, execute there, pc wraps to 0 which now holds a halt
        do_reset();
        mem[0]   = 32'hDFE0_0000;
        mem[255] = 32'h2000_0000;
        exec_ready = 1'b1;
        pulse_start();
        tick();
        mem[0] = 32'hE000_0000;
        run_to_done(20);
        check("t5_pc_wrap", pc, 0);
        check("t5_retired", retired, 1);
        check("t5_fetches", f_addr.size(), 3);
        if (f_addr.size() >= 3) begin
            check("t5_addr1", f_addr[1], 255);
            check("t5_addr2", f_addr[2], 0);
        end

        // start while busy is ignored; start in HALT restarts
        do_reset();
        mem[0] = 32'hA000_0000;
        mem[1] = 32'hE000_0000;
        exec_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        pulse_start();
        check("t6_busy_start_valid", instr_valid, 1);
        check("t6_busy_start_pc", pc, 0);
        check("t6_busy_start_en", imem_en, 0);
        check("t6_busy", busy, 1);
        exec_ready = 1'b1;
        run_to_done(20);
        check("t6_retired_first", retired, 1);
        check("t6_pc_first", pc, 1);
        pulse_start();
        check("t6_restart_done", done, 0);
        check("t6_restart_retired", retired, 0);
        check("t6_restart_pc", pc, 0);
        check("t6_restart_busy", busy, 1);
        check("t6_restart_en", imem_en, 1);
        check("t6_restart_addr", imem_addr, 0);
        run_to_done(20);
        check("t6_retired_second", retired, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
